// File: rtl/emif_pkg.sv
// Shared types and constants for the EMIF MCU-to-FPGA configuration receiver.
package emif_pkg;

    localparam int unsigned EMIF_ADDR_W = 13;
    localparam int unsigned EMIF_DATA_W = 16;
    localparam int unsigned CFG_W       = 2 * EMIF_DATA_W;

    // The high half of each configuration word lives two bytes above its low half.
    localparam logic [EMIF_ADDR_W-1:0] HI_OFFSET = EMIF_ADDR_W'(2);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        LO_HELD = 1'b1
    } emif_state_e;

    typedef struct packed {
        logic [EMIF_ADDR_W-1:0] addr;
        logic [EMIF_DATA_W-1:0] data;
    } emif_wr_t;

    function automatic logic [CFG_W-1:0] join_halves(input logic [EMIF_DATA_W-1:0] hi,
                                                     input logic [EMIF_DATA_W-1:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/emif_cmd_rx_if.sv
// EMIF write-side bus as seen from the MCU (master) and the FPGA receiver (slave).
interface emif_cmd_rx_if;
    import emif_pkg::*;

    logic                   emif_cs_n;
    logic                   emif_we_n;
    logic [EMIF_ADDR_W-1:0] emif_addr;
    logic [EMIF_DATA_W-1:0] emif_data;

    modport master (
        output emif_cs_n,
        output emif_we_n,
        output emif_addr,
        output emif_data
    );

    modport slave (
        input emif_cs_n,
        input emif_we_n,
        input emif_addr,
        input emif_data
    );

endinterface

// File: rtl/emif_strobe_sync.sv
// Brings the asynchronous EMIF write strobe into clk and emits a one-cycle write event
// together with the address/data captured through matching register stages.
module emif_strobe_sync
    import emif_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cs_n,
    input  logic                   we_n,
    input  logic [EMIF_ADDR_W-1:0] addr,
    input  logic [EMIF_DATA_W-1:0] data,
    output emif_wr_t               wr,
    output logic                   wr_ev
);

    logic     cs_meta;
    logic     cs_sync;
    logic     we_meta;
    logic     we_sync;
    logic     we_sync_d;
    emif_wr_t wr_s1;

    // Two-flop synchronisers; strobes reset to their inactive (high) level.
    always_ff @(posedge clk or posedge rst) begin : strobe_sync
        if (rst) begin
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            we_meta   <= 1'b1;
            we_sync   <= 1'b1;
            we_sync_d <= 1'b1;
        end else begin
            cs_meta   <= cs_n;
            cs_sync   <= cs_meta;
            we_meta   <= we_n;
            we_sync   <= we_meta;
            we_sync_d <= we_sync;
        end
    end

    // Address/data follow the same two-stage path so they line up with the strobes.
    always_ff @(posedge clk or posedge rst) begin : payload_align
        if (rst) begin
            wr_s1 <= '0;
            wr    <= '0;
        end else begin
            wr_s1 <= {addr, data};
            wr    <= wr_s1;
        end
    end

    // Write completes on the we_n rising edge, only while the chip is selected.
    always_ff @(posedge clk or posedge rst) begin : edge_detect
        if (rst) begin
            wr_ev <= 1'b0;
        end else begin
            wr_ev <= we_sync & ~we_sync_d & ~cs_sync;
        end
    end

endmodule

// File: rtl/emif_cmd_rx.sv
// EMIF configuration receiver: assembles 16-bit halves into two 32-bit config words.
// Optional pending-half timeout enabled by defining EMIF_CMD_TIMEOUT_EN.
module emif_cmd_rx
    import emif_pkg::*;
#(
    parameter logic [EMIF_ADDR_W-1:0] REG0_ADDR   = 13'h000,
    parameter logic [EMIF_ADDR_W-1:0] REG1_ADDR   = 13'h004,
    parameter int unsigned            TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,
    emif_cmd_rx_if.slave       emif,
    output logic [CFG_W-1:0]   cfg_word0,
    output logic [CFG_W-1:0]   cfg_word1,
    output logic               cfg_upd,
    output logic               cfg_upd_idx,
    output logic               seq_err
);

    localparam logic [EMIF_ADDR_W-1:0] REG0_HI = EMIF_ADDR_W'(REG0_ADDR + HI_OFFSET);
    localparam logic [EMIF_ADDR_W-1:0] REG1_HI = EMIF_ADDR_W'(REG1_ADDR + HI_OFFSET);

    emif_wr_t               wr;
    logic                   wr_ev;
    emif_state_e            state_q;
    emif_state_e            state_d;
    logic [EMIF_DATA_W-1:0] lo_hold_q;
    logic                   pend_idx_q;

    logic is_lo0_c;
    logic is_lo1_c;
    logic is_hi0_c;
    logic is_hi1_c;
    logic hi_pend_c;
    logic hi_other_c;
    logic timeout_c;
    logic store_lo_c;
    logic commit_c;
    logic err_c;

    emif_strobe_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .cs_n  (emif.emif_cs_n),
        .we_n  (emif.emif_we_n),
        .addr  (emif.emif_addr),
        .data  (emif.emif_data),
        .wr    (wr),
        .wr_ev (wr_ev)
    );

    assign is_lo0_c   = (wr.addr == REG0_ADDR);
    assign is_lo1_c   = (wr.addr == REG1_ADDR);
    assign is_hi0_c   = (wr.addr == REG0_HI);
    assign is_hi1_c   = (wr.addr == REG1_HI);
    assign hi_pend_c  = pend_idx_q ? is_hi1_c : is_hi0_c;
    assign hi_other_c = pend_idx_q ? is_hi0_c : is_hi1_c;

`ifdef EMIF_CMD_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TO_W-1:0] to_cnt_q;

    // Counts idle cycles spent holding a low half; any write event restarts it.
    always_ff @(posedge clk or posedge rst) begin : timeout_cnt
        if (rst) begin
            to_cnt_q <= '0;
        end else if ((state_q != LO_HELD) || wr_ev) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    assign timeout_c = (state_q == LO_HELD) && !wr_ev
                    && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_c;

    // Without the timeout the low half waits indefinitely for its partner.
    assign unused_timeout_c = ^TIMEOUT_CYC;
    assign timeout_c        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin : state_reg
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wr_ev && (is_lo0_c || is_lo1_c)) begin
                    state_d = LO_HELD;
                end
            end
            LO_HELD: begin
                if (wr_ev) begin
                    if (hi_pend_c || hi_other_c) begin
                        state_d = IDLE;
                    end
                end else if (timeout_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A low-address write while holding re-arms with the new half but flags the lost one.
    always_comb begin : output_decode
        store_lo_c = 1'b0;
        commit_c   = 1'b0;
        err_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_ev) begin
                    if (is_lo0_c || is_lo1_c) begin
                        store_lo_c = 1'b1;
                    end else if (is_hi0_c || is_hi1_c) begin
                        err_c = 1'b1;
                    end
                end
            end
            LO_HELD: begin
                if (wr_ev) begin
                    if (hi_pend_c) begin
                        commit_c = 1'b1;
                    end else if (is_lo0_c || is_lo1_c) begin
                        store_lo_c = 1'b1;
                        err_c      = 1'b1;
                    end else if (hi_other_c) begin
                        err_c = 1'b1;
                    end
                end else if (timeout_c) begin
                    err_c = 1'b1;
                end
            end
            default: begin
                err_c = 1'b0;
            end
        endcase
    end

    // Register bank: a commit replaces only the addressed word, all 32 bits at once.
    always_ff @(posedge clk or posedge rst) begin : reg_bank
        if (rst) begin
            cfg_word0   <= '0;
            cfg_word1   <= '0;
            cfg_upd     <= 1'b0;
            cfg_upd_idx <= 1'b0;
            seq_err     <= 1'b0;
            lo_hold_q   <= '0;
            pend_idx_q  <= 1'b0;
        end else begin
            cfg_upd <= commit_c;
            seq_err <= err_c;
            if (store_lo_c) begin
                lo_hold_q  <= wr.data;
                pend_idx_q <= is_lo1_c;
            end
            if (commit_c) begin
                cfg_upd_idx <= pend_idx_q;
                if (pend_idx_q) begin
                    cfg_word1 <= join_halves(wr.data, lo_hold_q);
                end else begin
                    cfg_word0 <= join_halves(wr.data, lo_hold_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_emif_cmd_rx.sv
// Directed bench for emif_cmd_rx: vector table of EMIF writes plus reset/timeout sequences.
module tb_emif_cmd_rx;

`ifdef EMIF_CMD_TIMEOUT_EN
    localparam int unsigned TB_TO = 16;
`else
    localparam int unsigned TB_TO = 1024;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] cfg_word0;
    logic [31:0] cfg_word1;
    logic        cfg_upd;
    logic        cfg_upd_idx;
    logic        seq_err;

    int errors;
    int checks;

    emif_cmd_rx_if bus ();

    emif_cmd_rx #(
        .REG0_ADDR   (13'h000),
        .REG1_ADDR   (13'h004),
        .TIMEOUT_CYC (TB_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .emif        (bus.slave),
        .cfg_word0   (cfg_word0),
        .cfg_word1   (cfg_word1),
        .cfg_upd     (cfg_upd),
        .cfg_upd_idx (cfg_upd_idx),
        .seq_err     (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] addr;
        logic [15:0] data;
        logic        upd;
        logic        idx;
        logic        err;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One EMIF write; we_n rises on a negedge, then six negedges are observed after it.
    task automatic emif_write(input logic [12:0] a, input logic [15:0] d, input logic cs,
                              output int upd_at, output int upd_cnt,
                              output int err_at, output int err_cnt, output logic idx);
        upd_at  = 0;
        upd_cnt = 0;
        err_at  = 0;
        err_cnt = 0;
        idx     = 1'b0;
        @(negedge clk);
        bus.emif_addr = a;
        bus.emif_data = d;
        bus.emif_cs_n = ~cs;
        bus.emif_we_n = 1'b0;
        repeat (3) @(negedge clk);
        bus.emif_we_n = 1'b1;
        for (int s = 1; s <= 6; s++) begin
            @(negedge clk);
            if (cfg_upd) begin
                upd_cnt++;
                if (upd_at == 0) begin
                    upd_at = s;
                    idx    = cfg_upd_idx;
                end
            end
            if (seq_err) begin
                err_cnt++;
                if (err_at == 0) err_at = s;
            end
            if (s == 5) bus.emif_cs_n = 1'b1;
        end
    endtask

    initial begin
        int   ua, uc, ea, ec, ecount;
        logic ix;

        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.emif_cs_n = 1'b1;
        bus.emif_we_n = 1'b1;
        bus.emif_addr = '0;
        bus.emif_data = '0;

        vecs[0]  = '{13'h000, 16'h1234, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[1]  = '{13'h002, 16'hABCD, 1'b1, 1'b0, 1'b0, 32'hABCD1234, 32'h0};
        vecs[2]  = '{13'h004, 16'h5555, 1'b0, 1'b0, 1'b0, 32'hABCD1234, 32'h0};
        vecs[3]  = '{13'h006, 16'h00AA, 1'b1, 1'b1, 1'b0, 32'hABCD1234, 32'h00AA5555};
        vecs[4]  = '{13'h002, 16'hFFFF, 1'b0, 1'b0, 1'b1, 32'hABCD1234, 32'h00AA5555};
        vecs[5]  = '{13'h000, 16'h1111, 1'b0, 1'b0, 1'b0, 32'hABCD1234, 32'h00AA5555};
        vecs[6]  = '{13'h004, 16'h2222, 1'b0, 1'b0, 1'b1, 32'hABCD1234, 32'h00AA5555};
        vecs[7]  = '{13'h006, 16'h3333, 1'b1, 1'b1, 1'b0, 32'hABCD1234, 32'h33332222};
        vecs[8]  = '{13'h010, 16'hBEEF, 1'b0, 1'b0, 1'b0, 32'hABCD1234, 32'h33332222};
        vecs[9]  = '{13'h004, 16'h7777, 1'b0, 1'b0, 1'b0, 32'hABCD1234, 32'h33332222};
        vecs[10] = '{13'h00C, 16'h0000, 1'b0, 1'b0, 1'b0, 32'hABCD1234, 32'h33332222};
        vecs[11] = '{13'h002, 16'h9999, 1'b0, 1'b0, 1'b1, 32'hABCD1234, 32'h33332222};
        vecs[12] = '{13'h006, 16'h4444, 1'b0, 1'b0, 1'b1, 32'hABCD1234, 32'h33332222};
        vecs[13] = '{13'h000, 16'hAAAA, 1'b0, 1'b0, 1'b0, 32'hABCD1234, 32'h33332222};

        repeat (3) @(negedge clk);
        chk("rst_word0", cfg_word0, 32'h0);
        chk("rst_word1", cfg_word1, 32'h0);
        chk("rst_upd", 32'(cfg_upd), 32'h0);
        chk("rst_idx", 32'(cfg_upd_idx), 32'h0);
        chk("rst_err", 32'(seq_err), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            emif_write(vecs[i].addr, vecs[i].data, 1'b1, ua, uc, ea, ec, ix);
            chk($sformatf("v%0d_upd_at", i), 32'(ua), vecs[i].upd ? 32'd4 : 32'd0);
            chk($sformatf("v%0d_upd_cnt", i), 32'(uc), 32'(vecs[i].upd));
            chk($sformatf("v%0d_err_at", i), 32'(ea), vecs[i].err ? 32'd4 : 32'd0);
            chk($sformatf("v%0d_err_cnt", i), 32'(ec), 32'(vecs[i].err));
            if (vecs[i].upd) chk($sformatf("v%0d_idx", i), 32'(ix), 32'(vecs[i].idx));
            chk($sformatf("v%0d_word0", i), cfg_word0, vecs[i].w0);
            chk($sformatf("v%0d_word1", i), cfg_word1, vecs[i].w1);
        end

        // Pending low half from vecs[13]: high half with cs_n inactive must not commit.
        emif_write(13'h002, 16'hCAFE, 1'b0, ua, uc, ea, ec, ix);
        chk("nocs_upd", 32'(uc), 32'd0);
        chk("nocs_err", 32'(ec), 32'd0);
        emif_write(13'h002, 16'hCAFE, 1'b1, ua, uc, ea, ec, ix);
        chk("cs_upd_at", 32'(ua), 32'd4);
        chk("cs_idx", 32'(ix), 32'd0);
        chk("cs_word0", cfg_word0, 32'hCAFEAAAA);
        chk("cs_word1", cfg_word1, 32'h33332222);

        // Reset in the middle of a sequence discards the pending low half.
        emif_write(13'h000, 16'h1111, 1'b1, ua, uc, ea, ec, ix);
        emif_write(13'h002, 16'h2222, 1'b0, ua, uc, ea, ec, ix);
        chk("mid_nocs_upd", 32'(uc), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_word0", cfg_word0, 32'h0);
        chk("mid_rst_word1", cfg_word1, 32'h0);
        chk("mid_rst_upd", 32'(cfg_upd), 32'h0);
        chk("mid_rst_err", 32'(seq_err), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        emif_write(13'h002, 16'h3333, 1'b1, ua, uc, ea, ec, ix);
        chk("post_rst_upd", 32'(uc), 32'd0);
        chk("post_rst_err_at", 32'(ea), 32'd4);
        chk("post_rst_word0", cfg_word0, 32'h0);

        // Long gap between halves.
        emif_write(13'h000, 16'h5A5A, 1'b1, ua, uc, ea, ec, ix);
        ecount = 0;
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            if (seq_err) ecount++;
        end
        emif_write(13'h002, 16'hA5A5, 1'b1, ua, uc, ea, ec, ix);
`ifdef EMIF_CMD_TIMEOUT_EN
        chk("to_err_pulses", 32'(ecount), 32'd1);
        chk("to_late_upd", 32'(uc), 32'd0);
        chk("to_late_err_at", 32'(ea), 32'd4);
        chk("to_word0", cfg_word0, 32'h0);
`else
        chk("gap_err_pulses", 32'(ecount), 32'd0);
        chk("gap_upd_at", 32'(ua), 32'd4);
        chk("gap_err_cnt", 32'(ec), 32'd0);
        chk("gap_word0", cfg_word0, 32'hA5A55A5A);
        chk("gap_word1", cfg_word1, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/emif_cmd_rx.md
Name: emif_cmd_rx

Overview:
- Receiver for the MCU-to-FPGA direction of the EMIF bus.
- The MCU writes two 32-bit configuration words as 16-bit halves: the low half first, then the high half.
- The block synchronises the asynchronous EMIF write strobe into the 200 MHz domain, assembles the halves, and commits each complete word atomically to a configuration register.
- Downstream logic (encoder mode/config) consumes the registers. The block sits beside the FPGA-to-MCU data-output path on the same EMIF interface.

Parameters:
- REG0_ADDR, 13'h000, address of the word 0 low half; the high half is at REG0_ADDR+2.
- REG1_ADDR, 13'h004, address of the word 1 low half; the high half is at REG1_ADDR+2.
- TIMEOUT_CYC, 1024, clk cycles a pending low half may wait for its high half (used only with the optional feature).

Ports:
- clk  in  1  200 MHz system clock.
- rst  in  1  Reset; asynchronous, active-high.
- emif_cs_n  in  1  EMIF chip select, active-low, asynchronous to clk.
- emif_we_n  in  1  EMIF write enable, active-low, asynchronous to clk.
- emif_addr  in  13  EMIF address.
- emif_data  in  16  EMIF write data from the MCU.
- cfg_word0  out  32  Committed configuration word 0.
- cfg_word1  out  32  Committed configuration word 1.
- cfg_upd  out  1  One-cycle pulse when a word commits.
- cfg_upd_idx  out  1  Index of the committed word; valid with cfg_upd.
- seq_err  out  1  One-cycle pulse on a protocol sequence violation.

Behaviour:
- Reset values: cfg_word0=0, cfg_word1=0, cfg_upd=0, cfg_upd_idx=0, seq_err=0. Reset clears the internal low-half holding register and pending index, and forces state IDLE. Reset mid-sequence discards a pending low half.
- Synchronisation:
  - emif_cs_n and emif_we_n each pass through a 2-flop synchroniser.
  - emif_addr and emif_data pass through 2 register stages in parallel so they stay aligned with the strobes.
  - Bus timing is configured so addr/data are stable from ≥2 clk before to ≥4 clk after the we_n rising edge.
- Write event: one-cycle internal strobe wr_ev when the synchronised we_n goes 0→1 while the synchronised cs_n=0. A we_n rise with cs_n=1 is ignored.
- Latency: cfg_word/cfg_upd update on the 4th rising clk edge after the pin-level we_n rise: 2 sync stages, 1 edge detect, 1 output register.
- FSM states: IDLE, LO_HELD.
- IDLE:
  - wr_ev at REGn_ADDR: store data as lo_hold, pend_idx=n, go to LO_HELD.
  - wr_ev at REGn_ADDR+2: ignored, seq_err pulse, stay IDLE.
  - Any other address: ignored, no pulse.
- LO_HELD:
  - wr_ev at REG[pend_idx]_ADDR+2: cfg_word[pend_idx] = {data, lo_hold}, cfg_upd=1, cfg_upd_idx=pend_idx, go to IDLE.
  - wr_ev at any REGn_ADDR (low address): overwrite lo_hold, pend_idx=n, seq_err pulse, stay LO_HELD.
  - wr_ev at the high address of the other word: pending discarded, seq_err pulse, go to IDLE; the other word is not modified.
  - Unmapped address: ignored; state and pending data unchanged.
- Commit is atomic: the 32-bit word changes in one cycle, and the non-addressed word is never disturbed.
- cfg_upd and seq_err never assert in the same cycle.
- At most one wr_ev per 3 cycles by construction; back-to-back EMIF writes are handled with no loss.

Optional Feature:
- EMIF_CMD_TIMEOUT_EN defined:
  - A counter runs while in LO_HELD and resets on each wr_ev.
  - When it reaches TIMEOUT_CYC-1, the pending data is discarded, seq_err pulses once, and the FSM returns to IDLE.
- Undefined: no counter; LO_HELD waits indefinitely.

Decomposition:
- Shared package emif_pkg: FSM state enum (IDLE, LO_HELD), EMIF_ADDR_W=13, EMIF_DATA_W=16, high-half offset constant 2.
- Sub-module emif_strobe_sync: 2-flop cs_n/we_n synchroniser, addr/data alignment stages, and wr_ev edge detection with cs qualification.
- FSM and register bank stay in emif_cmd_rx.

Test Plan:
- Write addr 0x000 data 0x1234, then addr 0x002 data 0xABCD -> cfg_word0=0xABCD1234; cfg_upd pulses with idx 0 exactly 4 clks after the second we_n rise; cfg_word1 stays 0.
- Write 0x004=0x5555, then 0x006=0x00AA -> cfg_word1=0x00AA5555, idx 1; cfg_word0 unchanged.
- Write 0x002=0xFFFF from IDLE -> seq_err pulse; no cfg_upd; both words unchanged.
- Write 0x000=0x1111, then 0x004=0x2222, then 0x006=0x3333 -> seq_err on the second write; cfg_word1=0x33332222; cfg_word0 unchanged.
- Write 0x000=0x1111, pulse we_n with cs_n=1 at 0x002, assert rst mid-sequence, then write 0x002 -> no commit; after reset all outputs 0; the final write gives seq_err.
- With EMIF_CMD_TIMEOUT_EN and TIMEOUT_CYC=16: write 0x000, idle 20 clks -> seq_err once, back to IDLE; a later 0x002 write gives seq_err and no commit.
